divider32_seq: RTL and testbench

- Multi-cycle unsigned restoring divider for the calculator datapath. It performs the inverse of the adder chain: repeated trial subtraction, one quotient bit per clock.
- Accepts a dividend/divisor pair on a valid/ready input handshake and returns quotient, remainder and a divide-by-zero flag on a valid/ready output handshake.
- Sits beside the adder in the calculator execute stage and is selected by the calculator control for DIV/MOD operations.

---
 rtl/calculator_pkg.sv | 19 +
 rtl/full_adder.sv | 19 +
 rtl/subtractor.sv | 36 +++
 rtl/divider32_seq.sv | 114 +++++++++++
 tb/tb_divider32_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/calculator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calculator_pkg
// Description : Shared width and divider state encoding for the calculator
//               execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package calculator_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : One-bit full adder cell used by the ripple subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule
`default_nettype wire

// File: rtl/subtractor.sv
`default_nettype none
// ============================================================================
// Module      : subtractor
// Description : Combinational ripple-borrow a - b, formed as a + ~b + 1.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] w_carry;

    // Carry-in of one completes the two's-complement negation of b
    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < W; i++) begin : g_bit
            full_adder u_fa (
                .i_a (a_i[i]),
                .i_b (~b_i[i]),
                .i_c (w_carry[i]),
                .o_s (diff_o[i]),
                .o_c (w_carry[i+1])
            );
        end
    endgenerate

    assign borrow_o = ~w_carry[W];

endmodule
`default_nettype wire

// File: rtl/divider32_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider32_seq
// Description : Multi-cycle unsigned restoring divider, one quotient bit per
//               clock, valid/ready on both operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module divider32_seq
    import calculator_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div_by_zero_o
);

    localparam int                CNT_W  = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(DATA_W - 1);

    div_state_t        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_divisor;
    logic              r_dbz;

    logic [DATA_W:0]   w_partial;
    logic [DATA_W:0]   w_diff;
    logic              w_borrow;
    logic              w_take;

    assign w_partial = {r_rem, r_q[DATA_W-1]};

    subtractor #(
        .W (DATA_W + 1)
    ) u_sub (
        .a_i      (w_partial),
        .b_i      ({1'b0, r_divisor}),
        .diff_o   (w_diff),
        .borrow_o (w_borrow)
    );

    // Since rem < divisor, a borrow-free diff never sets its top bit; the
    // term only makes the full subtractor result part of the decision.
    assign w_take = ~w_borrow & ~w_diff[DATA_W];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= DIV_IDLE;
            r_count   <= '0;
            r_q       <= '0;
            r_rem     <= '0;
            r_divisor <= '0;
            r_dbz     <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (in_valid_i) begin
                        r_state   <= DIV_RUN;
                        r_count   <= '0;
                        r_divisor <= divisor_i;
                        if (divisor_i == '0) begin
                            r_q   <= '1;
                            r_rem <= dividend_i;
                            r_dbz <= 1'b1;
                        end else begin
                            r_q   <= dividend_i;
                            r_rem <= '0;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                DIV_RUN: begin
                    // Divide-by-zero results are already final; spend one
                    // cycle here so they surface one edge after acceptance.
                    if (r_dbz) begin
                        r_state <= DIV_DONE;
                    end else begin
                        r_rem   <= w_take ? w_diff[DATA_W-1:0] : w_partial[DATA_W-1:0];
                        r_q     <= {r_q[DATA_W-2:0], w_take};
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == c_last) begin
                            r_state <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    if (out_ready_i) begin
                        r_state <= DIV_IDLE;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o    = (r_state == DIV_IDLE);
    assign out_valid_o   = (r_state == DIV_DONE);
    assign quotient_o    = r_q;
    assign remainder_o   = r_rem;
    assign div_by_zero_o = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divider32_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider32_seq
// Description : Self-checking bench for divider32_seq: directed vector table,
//               backpressure, reset-abort and a randomised stall regression.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider32_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        div_by_zero_o;

    int n_tests = 0;
    int n_fail  = 0;

    divider32_seq dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one operand pair for a single edge (the accept edge E0).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dividend_i = a;
        divisor_i  = b;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
    endtask

    // Counts edges after E0 until out_valid_o is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid_o && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez, input string nm);
        int n;
        n = 0;
        while (!in_ready_o && n < 100) begin
            tick();
            n++;
        end
        check({nm, " ready before accept"}, 32'(in_ready_o), 32'd1);
        issue(a, b);
        wait_valid(n);
        check({nm, " latency"}, n, (b == 0) ? 32'd1 : 32'd32);
        check({nm, " quotient"}, quotient_o, eq);
        check({nm, " remainder"}, remainder_o, er);
        check({nm, " dbz"}, 32'(div_by_zero_o), 32'(ez));
        tick();
        check({nm, " valid drop"}, 32'(out_valid_o), 32'd0);
        check({nm, " ready return"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[10];
        int          n;
        logic [31:0] a, b, eq, er;
        logic        ez, got;

        vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
        vecs[3] = '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0};
        vecs[4] = '{32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678,  1'b1};
        vecs[5] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
        vecs[6] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
        vecs[7] = '{32'h8000_0000,  32'd3,          32'd715827882,  32'd2,          1'b0};
        vecs[8] = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0};
        vecs[9] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        dividend_i  = '0;
        divisor_i   = '0;
        tick();
        tick();
        check("reset in_ready", 32'(in_ready_o), 32'd1);
        check("reset out_valid", 32'(out_valid_o), 32'd0);
        check("reset quotient", quotient_o, 32'd0);
        check("reset remainder", remainder_o, 32'd0);
        check("reset dbz", 32'(div_by_zero_o), 32'd0);
        rst_i = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));
        end

        // Backpressure: 1000/33 held for ten cycles while new operands knock.
        out_ready_i = 1'b0;
        issue(32'd1000, 32'd33);
        wait_valid(n);
        check("bp latency", n, 32'd32);
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'b1;
            dividend_i = $urandom;
            divisor_i  = $urandom;
            tick();
            check("bp hold valid", 32'(out_valid_o), 32'd1);
            check("bp hold quotient", quotient_o, 32'd30);
            check("bp hold remainder", remainder_o, 32'd10);
            check("bp hold in_ready", 32'(in_ready_o), 32'd0);
        end
        // Release with in_valid still high: that request must not be taken.
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("bp release valid", 32'(out_valid_o), 32'd0);
        check("bp same-edge not accepted", 32'(in_ready_o), 32'd1);
        tick();
        check("bp consumed once", 32'(out_valid_o), 32'd0);

        // Reset partway through 50000/7.
        issue(32'd50000, 32'd7);
        for (int i = 0; i < 15; i++) tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("abort in_ready", 32'(in_ready_o), 32'd1);
        check("abort out_valid", 32'(out_valid_o), 32'd0);
        check("abort quotient", quotient_o, 32'd0);
        check("abort remainder", remainder_o, 32'd0);
        check("abort dbz", 32'(div_by_zero_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid_o) begin
                check("abort no result", 32'(out_valid_o), 32'd0);
                break;
            end
        end
        run_op(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "post-abort 9/4");

        // Random regression with random result stalls.
        for (int k = 0; k < 800; k++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            ez = (b == 0);
            eq = ez ? 32'hFFFF_FFFF : a / b;
            er = ez ? a : a % b;
            issue(a, b);
            got = 1'b0;
            n   = 0;
            while (!got && n < 200) begin
                if (out_valid_o) begin
                    out_ready_i = ($urandom_range(0, 2) != 0);
                    if (out_ready_i) begin
                        n_tests++;
                        if (quotient_o !== eq || remainder_o !== er || div_by_zero_o !== ez) begin
                            n_fail++;
                            $display("FAIL rand%0d %h/%h: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                                     k, a, b, quotient_o, remainder_o, div_by_zero_o, eq, er, ez);
                        end
                        got = 1'b1;
                    end
                end
                tick();
                n++;
            end
            check($sformatf("rand%0d arrived", k), 32'(got), 32'd1);
            check($sformatf("rand%0d once", k), 32'(out_valid_o), 32'd0);
        end
        out_ready_i = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
